// File: rtl/apb_intercon_rr_if.sv
// apb_intercon_rr_if: core-side and slave-side APB3 buses of the round-robin interconnect
interface apb_intercon_rr_if #(
    parameter int BUS_WIDTH    = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int MASTER_PORTS = 4,
    parameter int SLAVE_PORTS  = 8
);
    logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR;
    logic [MASTER_PORTS-1:0]            S_PWRITE;
    logic [MASTER_PORTS-1:0]            S_PSELx;
    logic [MASTER_PORTS-1:0]            S_PENABLE;
    logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA;
    logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA;
    logic [MASTER_PORTS-1:0]            S_PREADY;
    logic [MASTER_PORTS-1:0]            S_PSLVERR;
    logic [BUS_WIDTH-1:0]               M_PADDR;
    logic                               M_PWRITE;
    logic [SLAVE_PORTS-1:0]             M_PSELx;
    logic                               M_PENABLE;
    logic [DATA_WIDTH-1:0]              M_PWDATA;
    logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA;
    logic [SLAVE_PORTS-1:0]             M_PREADY;
    logic [SLAVE_PORTS-1:0]             M_PSLVERR;

    // master: the interconnect itself; slave: the cores and peripherals around it
    modport master (
        input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY, M_PSLVERR,
        output S_PRDATA, S_PREADY, S_PSLVERR, M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
    );
    modport slave (
        output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA, M_PRDATA, M_PREADY, M_PSLVERR,
        input  S_PRDATA, S_PREADY, S_PSLVERR, M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA
    );
endinterface

// File: rtl/apb_intercon_rr.sv
// apb_intercon_rr: N-master to M-slave APB3 interconnect with round-robin arbitration,
// base/mask address decode, and decode-miss / timeout error responses.
module apb_intercon_rr #(
    parameter int BUS_WIDTH      = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int MASTER_PORTS   = 4,
    parameter int SLAVE_PORTS    = 8,
    parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_MASK = '0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    apb_intercon_rr_if.master bus,
    output logic busy,
    output logic [(MASTER_PORTS > 1 ? $clog2(MASTER_PORTS) : 1)-1:0] grant_idx
);
    localparam int GW = MASTER_PORTS > 1 ? $clog2(MASTER_PORTS) : 1;
    localparam logic [31:0] TO = TIMEOUT_CYCLES;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state;

    logic [GW-1:0]                      ptr, gnt_n;
    logic                               found;
    logic [BUS_WIDTH-1:0]               addr_n;
    logic [SLAVE_PORTS-1:0]             dec;
    logic [31:0]                        cnt;
    logic                               acc_rdy, timeout, r_err;
    logic [DATA_WIDTH-1:0]              sdata, r_data;
    logic [MASTER_PORTS-1:0]            rdy_v, err_v;
    logic [MASTER_PORTS*DATA_WIDTH-1:0] rdat_v;

    // first requester at or after the pointer, wrapping
    always_comb begin
        gnt_n = ptr;
        found = 1'b0;
        for (int i = 0; i < MASTER_PORTS; i++) begin
            if (!found && bus.S_PSELx[(int'(ptr) + i) % MASTER_PORTS]) begin
                gnt_n = GW'((int'(ptr) + i) % MASTER_PORTS);
                found = 1'b1;
            end
        end
    end

    // descending scan so the lowest matching slave index wins
    always_comb begin
        addr_n = bus.S_PADDR[gnt_n*BUS_WIDTH +: BUS_WIDTH];
        dec = '0;
        for (int i = SLAVE_PORTS - 1; i >= 0; i--) begin
            if ((addr_n & SLAVE_MASK[i*BUS_WIDTH +: BUS_WIDTH]) == SLAVE_BASE[i*BUS_WIDTH +: BUS_WIDTH])
                dec = SLAVE_PORTS'(1) << i;
        end
    end

    always_comb begin
        sdata = '0;
        for (int i = 0; i < SLAVE_PORTS; i++)
            sdata = sdata | (bus.M_PRDATA[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{bus.M_PSELx[i]}});
        acc_rdy = |(bus.M_PSELx & bus.M_PREADY);
        timeout = (TO != 0) && (cnt + 32'd1 == TO);
        // anything other than a real slave completion is an error with zero data
        r_data  = acc_rdy ? sdata : '0;
        r_err   = acc_rdy ? |(bus.M_PSELx & bus.M_PSLVERR) : 1'b1;
        for (int m = 0; m < MASTER_PORTS; m++) begin
            rdy_v[m] = grant_idx == GW'(m);
            err_v[m] = rdy_v[m] & r_err;
            rdat_v[m*DATA_WIDTH +: DATA_WIDTH] = rdy_v[m] ? r_data : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            grant_idx     <= '0;
            cnt           <= '0;
            busy          <= 1'b0;
            bus.M_PADDR   <= '0;
            bus.M_PWRITE  <= 1'b0;
            bus.M_PWDATA  <= '0;
            bus.M_PSELx   <= '0;
            bus.M_PENABLE <= 1'b0;
            bus.S_PREADY  <= '0;
            bus.S_PRDATA  <= '0;
            bus.S_PSLVERR <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state        <= SETUP;
                    busy         <= 1'b1;
                    grant_idx    <= gnt_n;
                    ptr          <= (gnt_n == GW'(MASTER_PORTS - 1)) ? '0 : gnt_n + 1'b1;
                    bus.M_PADDR  <= addr_n;
                    bus.M_PWRITE <= bus.S_PWRITE[gnt_n];
                    bus.M_PWDATA <= bus.S_PWDATA[gnt_n*DATA_WIDTH +: DATA_WIDTH];
                    bus.M_PSELx  <= dec;
                end
                SETUP: begin
                    state         <= |bus.M_PSELx ? ACCESS : RESP;
                    bus.M_PENABLE <= |bus.M_PSELx;
                    bus.S_PREADY  <= |bus.M_PSELx ? '0 : rdy_v;
                    bus.S_PRDATA  <= |bus.M_PSELx ? '0 : rdat_v;
                    bus.S_PSLVERR <= |bus.M_PSELx ? '0 : err_v;
                end
                ACCESS: begin
                    cnt <= cnt + 32'd1;
                    if (acc_rdy || timeout) begin
                        state         <= RESP;
                        bus.M_PSELx   <= '0;
                        bus.M_PENABLE <= 1'b0;
                        bus.S_PREADY  <= rdy_v;
                        bus.S_PRDATA  <= rdat_v;
                        bus.S_PSLVERR <= err_v;
                    end
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    cnt           <= '0;
                    bus.S_PREADY  <= '0;
                    bus.S_PRDATA  <= '0;
                    bus.S_PSLVERR <= '0;
                end
            endcase
        end
    end

    a_penable_needs_psel: assert property (@(posedge clk) disable iff (reset)
        (bus.S_PENABLE & ~bus.S_PSELx) == '0);
endmodule

// File: tb/tb_apb_intercon_rr.sv
// tb_apb_intercon_rr: directed checks of arbitration, decode, wait states, errors and reset.
module tb_apb_intercon_rr;
    localparam logic [127:0] BASE = {16'h0500, 16'h0500, 16'h0400, 16'h0300,
                                     16'h0200, 16'h0100, 16'h0000, 16'h4000};
    localparam logic [127:0] MASK = {{7{16'hFF00}}, 16'hF000};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [1:0] grant_idx;
    int         n_tests = 0;
    int         n_fail = 0;

    apb_intercon_rr_if #(.BUS_WIDTH(16), .DATA_WIDTH(16), .MASTER_PORTS(4), .SLAVE_PORTS(8)) bus ();

    apb_intercon_rr #(
        .BUS_WIDTH(16), .DATA_WIDTH(16), .MASTER_PORTS(4), .SLAVE_PORTS(8),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    logic [15:0] slv_data [8];
    logic [7:0]  slv_err = '0;
    int          wait_n = 0;
    bit          never = 1'b0;
    int          acc_cnt = 0;

    // slave model: ready after wait_n ACCESS cycles, never ready when 'never' is set
    always @(posedge clk) acc_cnt <= bus.M_PENABLE ? acc_cnt + 1 : 0;
    always_comb begin
        for (int i = 0; i < 8; i++) bus.M_PRDATA[i*16 +: 16] = slv_data[i];
        bus.M_PREADY  = {8{!never && acc_cnt >= wait_n}};
        bus.M_PSLVERR = slv_err;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int m, input logic [15:0] a, input logic w, input logic [15:0] d);
        bus.S_PADDR[m*16 +: 16]  = a;
        bus.S_PWRITE[m]          = w;
        bus.S_PWDATA[m*16 +: 16] = d;
        bus.S_PSELx              = 4'b1 << m;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int pen;
        for (int i = 0; i < 8; i++) slv_data[i] = 16'hA000 + 16'(i);
        slv_data[2] = 16'hBEEF;
        bus.S_PADDR = '0; bus.S_PWRITE = '0; bus.S_PSELx = '0; bus.S_PENABLE = '0; bus.S_PWDATA = '0;
        step();
        chk("rst_sel", 64'(bus.M_PSELx), 64'h0);
        chk("rst_rdy", 64'(bus.S_PREADY), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_addr", 64'(bus.M_PADDR), 64'h0);
        do_reset();

        req(1, 16'h0102, 1'b0, 16'h0);
        step();
        chk("rd_sel_c1", 64'(bus.M_PSELx), 64'h04);
        chk("rd_en_c1", 64'(bus.M_PENABLE), 64'h0);
        chk("rd_gnt", 64'(grant_idx), 64'h1);
        chk("rd_busy", 64'(busy), 64'h1);
        bus.S_PADDR[16 +: 16] = 16'h0302;
        step();
        chk("rd_sel_c2", 64'(bus.M_PSELx), 64'h04);
        chk("rd_en_c2", 64'(bus.M_PENABLE), 64'h1);
        chk("rd_addr_latched", 64'(bus.M_PADDR), 64'h0102);
        step();
        chk("rd_rdy", 64'(bus.S_PREADY), 64'h2);
        chk("rd_data", bus.S_PRDATA, 64'h0000_0000_BEEF_0000);
        chk("rd_err", 64'(bus.S_PSLVERR), 64'h0);
        chk("rd_sel_resp", 64'(bus.M_PSELx), 64'h0);
        bus.S_PSELx = '0;
        step();
        chk("rd_idle_busy", 64'(busy), 64'h0);
        chk("rd_idle_rdy", 64'(bus.S_PREADY), 64'h0);

        wait_n = 3;
        slv_err[4] = 1'b1;
        req(3, 16'h0305, 1'b1, 16'h1234);
        step();
        chk("wr_sel", 64'(bus.M_PSELx), 64'h10);
        chk("wr_write", 64'(bus.M_PWRITE), 64'h1);
        chk("wr_gnt", 64'(grant_idx), 64'h3);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("wr_wdata", 64'(bus.M_PWDATA), 64'h1234);
            chk("wr_en", 64'(bus.M_PENABLE), 64'h1);
            chk("wr_rdy_early", 64'(bus.S_PREADY), 64'h0);
        end
        step();
        chk("wr_rdy", 64'(bus.S_PREADY), 64'h8);
        chk("wr_err", 64'(bus.S_PSLVERR), 64'h8);
        bus.S_PSELx = '0; wait_n = 0; slv_err = '0;
        step();

        req(0, 16'h8000, 1'b0, 16'h0);
        step();
        chk("miss_sel", 64'(bus.M_PSELx), 64'h0);
        chk("miss_busy", 64'(busy), 64'h1);
        step();
        chk("miss_rdy", 64'(bus.S_PREADY), 64'h1);
        chk("miss_err", 64'(bus.S_PSLVERR), 64'h1);
        chk("miss_data", bus.S_PRDATA, 64'h0);
        chk("miss_en", 64'(bus.M_PENABLE), 64'h0);
        bus.S_PSELx = '0;
        step();

        req(2, 16'h0510, 1'b0, 16'h0);
        step();
        chk("ovl_sel", 64'(bus.M_PSELx), 64'h40);
        step();
        step();
        chk("ovl_rdy", 64'(bus.S_PREADY), 64'h4);
        chk("ovl_data", bus.S_PRDATA, 64'h0000_A006_0000_0000);
        bus.S_PSELx = '0;
        step();

        never = 1'b1;
        req(1, 16'h0000, 1'b0, 16'h0);
        step();
        pen = 0;
        for (int i = 0; i < 30 && bus.S_PREADY == '0; i++) begin
            if (bus.M_PENABLE) pen++;
            step();
        end
        chk("to_pen_cycles", 64'(pen), 64'd8);
        chk("to_rdy", 64'(bus.S_PREADY), 64'h2);
        chk("to_err", 64'(bus.S_PSLVERR), 64'h2);
        chk("to_data", bus.S_PRDATA, 64'h0);
        bus.S_PSELx = '0; never = 1'b0;
        step();
        req(1, 16'h0102, 1'b0, 16'h0);
        step();
        step();
        step();
        chk("post_to_rdy", 64'(bus.S_PREADY), 64'h2);
        chk("post_to_data", bus.S_PRDATA, 64'h0000_0000_BEEF_0000);
        chk("post_to_err", 64'(bus.S_PSLVERR), 64'h0);
        bus.S_PSELx = '0;
        step();

        do_reset();
        bus.S_PADDR = '0; bus.S_PWRITE = '0;
        bus.S_PSELx = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("fair_gnt", 64'(grant_idx), 64'(k % 4));
            chk("fair_busy", 64'(busy), 64'h1);
            step();
            step();
            chk("fair_rdy", 64'(bus.S_PREADY), 64'(4'b1 << (k % 4)));
            step();
            chk("fair_gap", 64'(busy), 64'h0);
            if (k == 5) bus.S_PSELx = '0;
        end
        step();

        never = 1'b1;
        req(0, 16'h0000, 1'b0, 16'h0);
        step();
        chk("rst_mid_gnt", 64'(grant_idx), 64'h0);
        step();
        chk("rst_mid_en", 64'(bus.M_PENABLE), 64'h1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_en0", 64'(bus.M_PENABLE), 64'h0);
        chk("rst_mid_sel0", 64'(bus.M_PSELx), 64'h0);
        chk("rst_mid_busy0", 64'(busy), 64'h0);
        chk("rst_mid_rdy0", 64'(bus.S_PREADY), 64'h0);
        bus.S_PSELx = '0; never = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("rst_no_resp", 64'(bus.S_PREADY), 64'h0);
        bus.S_PADDR = '0;
        bus.S_PSELx = 4'b0101;
        step();
        chk("rst_tie_gnt", 64'(grant_idx), 64'h0);
        chk("rst_tie_sel", 64'(bus.M_PSELx), 64'h02);
        bus.S_PSELx = 4'b0100;
        step();
        step();
        chk("rst_tie_rdy", 64'(bus.S_PREADY), 64'h1);
        bus.S_PSELx = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_intercon_rr.md
Name: apb_intercon_rr

Overview:
Parametrised N-master to M-slave APB3 interconnect for the vmicro16 SoC. It arbitrates core-side APB requests with a fair round-robin arbiter and locks the grant for a whole transfer. It decodes the latched address against a parameter-supplied base/mask map and generates clean SETUP/ACCESS phases toward the slaves. It returns PRDATA, PREADY and PSLVERR to the granted master, with decode-miss and timeout error responses.

Parameters:
BUS_WIDTH, 16, address width
DATA_WIDTH, 16, data width
MASTER_PORTS, 4, number of requesting masters (>=1)
SLAVE_PORTS, 8, number of slaves (>=1)
SLAVE_BASE, 0, packed SLAVE_PORTS*BUS_WIDTH base addresses; slave i at [i*BUS_WIDTH +: BUS_WIDTH]
SLAVE_MASK, 0, packed SLAVE_PORTS*BUS_WIDTH masks; same packing as SLAVE_BASE
TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles before abort; 0 disables the timeout

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
S_PADDR  in  MASTER_PORTS*BUS_WIDTH  master addresses
S_PWRITE  in  MASTER_PORTS  master write strobes
S_PSELx  in  MASTER_PORTS  master requests
S_PENABLE  in  MASTER_PORTS  master enables; ignored except for protocol checks
S_PWDATA  in  MASTER_PORTS*DATA_WIDTH  master write data
S_PRDATA  out  MASTER_PORTS*DATA_WIDTH  read data, valid with S_PREADY
S_PREADY  out  MASTER_PORTS  one-cycle completion pulse
S_PSLVERR  out  MASTER_PORTS  error flag, valid with S_PREADY
M_PADDR  out  BUS_WIDTH  latched address
M_PWRITE  out  1  latched write strobe
M_PSELx  out  SLAVE_PORTS  one-hot slave select
M_PENABLE  out  1  ACCESS-phase enable
M_PWDATA  out  DATA_WIDTH  latched write data
M_PRDATA  in  SLAVE_PORTS*DATA_WIDTH  slave read data
M_PREADY  in  SLAVE_PORTS  slave ready signals
M_PSLVERR  in  SLAVE_PORTS  slave error signals
busy  out  1  high whenever the FSM is not in IDLE
grant_idx  out  clog2(MASTER_PORTS)  index of the current or last granted master

Behaviour:
- Reset (async): state IDLE; every output 0; round-robin pointer 0 (master 0 highest priority); timeout counter 0.
- Decode: slave i matches when (addr & MASK_i) == BASE_i. If several match, the lowest index wins. No match is a decode miss.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any S_PSELx is high, grant the first requester at or after the pointer, searching upward and wrapping modulo MASTER_PORTS.
  - On grant: latch PADDR, PWRITE, PWDATA and the decode result into registers; set grant_idx; pointer <= grant+1 (wrapping); go to SETUP.
  - No request: remain in IDLE.
- SETUP:
  - Decode hit: M_PSELx one-hot high, M_PENABLE=0; go to ACCESS.
  - Decode miss: M_PSELx=0; go to RESP with err=1, rdata=0.
- ACCESS:
  - M_PSELx and M_PENABLE high; the counter increments each cycle.
  - On the selected slave's M_PREADY: capture its M_PRDATA and M_PSLVERR; go to RESP.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES without PREADY: abort with err=1, rdata=0; go to RESP.
  - M_PREADY from unselected slaves is ignored.
- RESP:
  - M_PSELx=0, M_PENABLE=0.
  - S_PREADY[grant]=1, S_PRDATA[grant]=captured data, S_PSLVERR[grant]=captured error; all other masters' outputs stay 0.
  - Next state IDLE; the counter clears.
- Latency: a request seen in IDLE at cycle 0 gives SETUP at cycle 1 and ACCESS at cycle 2. With a zero-wait slave, S_PREADY is high at cycle 3. Each slave wait state adds 1 cycle. A decode miss gives S_PREADY at cycle 2.
- Master rules:
  - A master holds PSELx and its payload until it sees S_PREADY, then drops PSELx.
  - The grant is locked; if the granted master drops PSELx early, the transfer still completes and the response is still driven.
  - A master still requesting in the IDLE cycle after its RESP is treated as a new request, arbitrated at lowest priority.
- Master payload changes after the grant are ignored, because the payload is latched.
- MASTER_PORTS=1: the arbiter degenerates to a constant grant, and grant_idx is a 1-bit constant 0.
- Reset asserted mid-transfer aborts immediately: no response is delivered and all outputs go to 0.

Test Plan:
- Single read, zero wait: master 1 reads 0x0102, mapping to slave 2 (BASE 0x0100, MASK 0xFF00), which returns 0xBEEF -> M_PSELx=0x04 at cycles 1-2, M_PENABLE at cycle 2, S_PREADY[1]=1 with S_PRDATA[1]=0xBEEF at cycle 3, PSLVERR=0.
- Fairness: all 4 masters request continuously after reset -> grants are 0,1,2,3,0,1, each transfer 4 cycles, busy drops 1 cycle between transfers.
- Wait states and write: master 3 writes 0x1234, slave PREADY is held low for 3 ACCESS cycles, M_PSLVERR=1 on completion -> M_PWDATA=0x1234 stable throughout, S_PREADY[3] at cycle 6, S_PSLVERR[3]=1.
- Decode miss: address matching no slave -> M_PSELx stays 0, S_PREADY=1 and S_PSLVERR=1 at cycle 2, S_PRDATA=0.
- Timeout: TIMEOUT_CYCLES=8, slave never ready -> M_PENABLE high for exactly 8 cycles, then S_PREADY=1 and S_PSLVERR=1; the next request is serviced normally.
- Reset during ACCESS: assert reset between clock edges -> all outputs 0 immediately; after release, the pointer is 0 and master 0 wins a tie against master 2.
